// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/done bus between mem_stage (master) and data memory (slave)
interface mem_stage_if;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;
   modport master(output mem_req, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_done);
   modport slave(input mem_req, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_done);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with data-memory handshake, timeout abort and MEM/WB register; MEM_ALIGN_CHK_EN enables odd-address rejection
module mem_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] aluResult,
   input  logic [15:0] storeData,
   input  logic [15:0] nextPC,
   input  logic [2:0]  regsel,
   input  logic        regWrite,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic        enJAL,
   mem_stage_if.master mem,
   output logic        stall,
   output logic        out_valid,
   output logic [15:0] wbData,
   output logic [2:0]  wbReg,
   output logic        wbEn,
   output logic        err
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        wr, wr_n, lwe, lwe_n;
   logic [15:0] addr, addr_n, wdata, wdata_n;
   logic [2:0]  lreg, lreg_n;
   logic        ov_n, wben_n, err_n;
   logic [15:0] wbdata_n;
   logic [2:0]  wbreg_n;
   logic        mem_op, misalign;
   assign mem_op = memRead | memWrite;
`ifdef MEM_ALIGN_CHK_EN
   assign misalign = aluResult[0];
`else
   assign misalign = 1'b0;
`endif
   assign stall         = state == BUSY;
   assign mem.mem_req   = stall;
   assign mem.mem_wr    = wr;
   assign mem.mem_addr  = addr;
   assign mem.mem_wdata = wdata;
   // next-state and next MEM/WB register values; retirement fields default to "no retire, hold data"
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      wr_n     = wr;
      addr_n   = addr;
      wdata_n  = wdata;
      lreg_n   = lreg;
      lwe_n    = lwe;
      ov_n     = 1'b0;
      wben_n   = 1'b0;
      err_n    = 1'b0;
      wbdata_n = wbData;
      wbreg_n  = wbReg;
      if (state == IDLE) begin
         if (in_valid && mem_op && !misalign) begin
            state_n = BUSY;
            cnt_n   = 8'd0;
            wr_n    = memWrite;
            addr_n  = aluResult;
            wdata_n = storeData;
            lreg_n  = regsel;
            lwe_n   = regWrite;
         end else if (in_valid) begin
            ov_n     = 1'b1;
            wbreg_n  = regsel;
            wbdata_n = (enJAL && !mem_op) ? nextPC : aluResult;
            wben_n   = regWrite & ~mem_op;
            err_n    = mem_op;
         end
      end else begin
         cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
         if (mem.mem_done) begin
            state_n  = IDLE;
            ov_n     = 1'b1;
            wbreg_n  = lreg;
            wbdata_n = wr ? addr : mem.mem_rdata;
            wben_n   = lwe & ~wr;
         end else if (cnt == LAST) begin
            state_n = IDLE;
            ov_n    = 1'b1;
            err_n   = 1'b1;
            wbreg_n = lreg;
         end
      end
   end
   // state, latched access and MEM/WB registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         wr        <= 1'b0;
         addr      <= 16'd0;
         wdata     <= 16'd0;
         lreg      <= 3'd0;
         lwe       <= 1'b0;
         out_valid <= 1'b0;
         wbData    <= 16'd0;
         wbReg     <= 3'd0;
         wbEn      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         wr        <= wr_n;
         addr      <= addr_n;
         wdata     <= wdata_n;
         lreg      <= lreg_n;
         lwe       <= lwe_n;
         out_valid <= ov_n;
         wbData    <= wbdata_n;
         wbReg     <= wbreg_n;
         wbEn      <= wben_n;
         err       <= err_n;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a latency-programmable memory responder
module tb_mem_stage;
   localparam int TO = 4;
`ifdef MEM_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, regWrite, memRead, memWrite, enJAL;
   logic [15:0] aluResult, storeData, nextPC;
   logic [2:0]  regsel;
   logic        stall, out_valid, wbEn, err;
   logic [15:0] wbData;
   logic [2:0]  wbReg;
   mem_stage_if bus();
   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .aluResult(aluResult), .storeData(storeData),
      .nextPC(nextPC), .regsel(regsel), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
      .enJAL(enJAL), .mem(bus), .stall(stall), .out_valid(out_valid), .wbData(wbData),
      .wbReg(wbReg), .wbEn(wbEn), .err(err)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [15:0] d;
      logic [2:0]  r;
      logic        en;
      logic        er;
      logic        chk;
   } exp_t;
   exp_t        q[$];
   int          tests = 0;
   int          fails = 0;
   int          lat_g = 0;
   int          len_g = 0;
   logic [15:0] rd_g = 16'd0, addr_g = 16'd0, wdata_g = 16'd0;
   logic        wr_g = 1'b0;
   logic [15:0] last_d;
   bit          last_known;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic issue(input logic iv, input logic [15:0] alu, input logic [15:0] sd,
                        input logic [15:0] npc, input logic [2:0] rs, input logic rw,
                        input logic mr, input logic mw, input logic jal, input int lat,
                        input logic [15:0] rd);
      exp_t e;
      int   n;
      in_valid = iv; aluResult = alu; storeData = sd; nextPC = npc; regsel = rs;
      regWrite = rw; memRead = mr; memWrite = mw; enJAL = jal;
      lat_g = lat; rd_g = rd; addr_g = alu; wdata_g = sd; wr_g = mw; len_g = 0;
      if (iv) begin
         if (!(mr | mw)) e = '{jal ? npc : alu, rs, rw, 1'b0, 1'b1};
         else if (ALIGN && alu[0]) e = '{alu, rs, 1'b0, 1'b1, 1'b1};
         else begin
            len_g = (lat < TO) ? lat + 1 : TO;
            if (lat >= TO) e = '{16'h0, rs, 1'b0, 1'b1, 1'b0};
            else if (mw) e = '{alu, rs, 1'b0, 1'b0, 1'b1};
            else e = '{rd, rs, rw, 1'b0, 1'b1};
         end
         q.push_back(e);
      end
      @(negedge clk);
      n = 0;
      while (stall && n < 50) begin
         in_valid = 1'($urandom); aluResult = 16'($urandom); storeData = 16'($urandom);
         regsel = 3'($urandom); memRead = 1'($urandom); memWrite = 1'($urandom);
         n++;
         @(negedge clk);
      end
      check("stall_bound", {31'd0, stall}, 32'd0);
      in_valid = 1'b0;
   endtask
   // monitor: pops the scoreboard on every retirement, checks idle/hold behaviour otherwise
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_d = 16'd0;
            last_known = 1'b1;
         end else if (out_valid) begin
            if (q.size() == 0) check("unexpected_retire", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               check("err", {31'd0, err}, {31'd0, e.er});
               check("wbEn", {31'd0, wbEn}, {31'd0, e.en});
               if (e.chk) begin
                  check("wbData", {16'd0, wbData}, {16'd0, e.d});
                  check("wbReg", {29'd0, wbReg}, {29'd0, e.r});
                  last_d = e.d;
                  last_known = 1'b1;
               end else last_known = 1'b0;
            end
         end else begin
            check("wbEn_idle", {31'd0, wbEn}, 32'd0);
            check("err_idle", {31'd0, err}, 32'd0);
            if (last_known) check("wbData_hold", {16'd0, wbData}, {16'd0, last_d});
         end
      end
   end
   // memory responder: done after the programmed number of busy cycles, checks the held bus
   initial begin
      int          k, lat, len;
      logic [15:0] a, w, rd;
      logic        wr;
      k = 0; lat = 0; len = 0; a = 16'd0; w = 16'd0; rd = 16'd0; wr = 1'b0;
      bus.mem_done = 1'b0;
      bus.mem_rdata = 16'd0;
      forever begin
         @(negedge clk);
         if (bus.mem_req) begin
            if (k == 0) begin
               lat = lat_g; len = len_g; a = addr_g; w = wdata_g; wr = wr_g; rd = rd_g;
            end
            check("mem_addr", {16'd0, bus.mem_addr}, {16'd0, a});
            check("mem_wr", {31'd0, bus.mem_wr}, {31'd0, wr});
            check("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, w});
            check("stall_busy", {31'd0, stall}, 32'd1);
            bus.mem_done = (k == lat);
            bus.mem_rdata = (k == lat) ? rd : 16'($urandom);
            k++;
         end else begin
            if (k > 0 && len >= 0) check("req_len", k, len);
            k = 0;
            bus.mem_done = ($urandom_range(0, 5) == 0);
            bus.mem_rdata = 16'($urandom);
         end
      end
   end
   initial begin
      int op;
      in_valid = 1'b0; aluResult = 16'd0; storeData = 16'd0; nextPC = 16'd0; regsel = 3'd0;
      regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0; enJAL = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
      check("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_wbData", {16'd0, wbData}, 32'd0);
      check("rst_wbReg", {29'd0, wbReg}, 32'd0);
      check("rst_wbEn", {31'd0, wbEn}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      issue(1'b1, 16'h1234, 16'h0, 16'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0);
      issue(1'b1, 16'h0000, 16'h0, 16'h0042, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 0, 16'h0);
      issue(1'b1, 16'h0100, 16'h0, 16'h0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3, 16'hBEEF);
      issue(1'b1, 16'h0200, 16'hCAFE, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 16'h0);
      issue(1'b1, 16'h0300, 16'h0, 16'h0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 99, 16'h0);
      issue(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0);
      issue(1'b1, 16'h0101, 16'h0, 16'h0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1, 16'h5555);
      issue(1'b1, 16'h0400, 16'h1111, 16'h0, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 2, 16'h7777);
      issue(1'b1, 16'h0010, 16'h0, 16'h0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 16'h0A0A);
      in_valid = 1'b1; aluResult = 16'h0500; regsel = 3'd5; regWrite = 1'b1;
      memRead = 1'b1; memWrite = 1'b0; enJAL = 1'b0;
      lat_g = 99; len_g = -1; addr_g = 16'h0500; wdata_g = storeData; wr_g = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 4);
         issue($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
               3'($urandom), 1'($urandom), op == 2 || op == 4, op == 3 || op == 4,
               1'($urandom), $urandom_range(0, 6), 16'($urandom));
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
